// File: rtl/flash_rd_cache.sv
// flash_rd_cache: 16-entry direct-mapped read cache in front of the flash
// word-fetch controller. Serves byte/word reads at any byte address; unaligned
// word reads are stitched from two consecutive words, byte reads are
// returned sign-extended.
module flash_rd_cache #(
  parameter int ENTRIES = 16
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [16:0] cpu_addr,
  input  logic        cpu_byte,
  output logic [15:0] cpu_data,
  output logic        cpu_ack,
  input  logic        flush,
  output logic        fl_req,
  output logic [15:0] fl_addr,
  input  logic [15:0] fl_rdata,
  input  logic        fl_ack,
  output logic [15:0] miss_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 16 - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOK0, S_FILL0, S_LOOK1, S_FILL1, S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [16:0]        addr_q, addr_d;
  logic               byte_q, byte_d;
  logic [15:0]        d0_q, d0_d;
  logic [15:0]        d1_q, d1_d;
  logic [15:0]        cpu_data_q, cpu_data_d;
  logic               fl_req_q, fl_req_d;
  logic [15:0]        fl_addr_q, fl_addr_d;
  logic [15:0]        miss_cnt_q, miss_cnt_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [15:0]        data_q [ENTRIES];

  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [TAG_W-1:0]   wr_tag;

  logic [15:0]        w0, w1;
  logic [IDX_W-1:0]   idx0, idx1;
  logic [TAG_W-1:0]   tag0, tag1;
  logic               hit0, hit1, need1;

  // Byte select with sign extension, or aligned / stitched word.
  function automatic logic [15:0] form_data(input logic is_byte, input logic a0,
                                            input logic [15:0] lo, input logic [15:0] hi);
    logic [7:0]  b;
    logic [15:0] r;
    b = a0 ? lo[15:8] : lo[7:0];
    if (is_byte)  r = {{8{b[7]}}, b};
    else if (a0)  r = {hi[7:0], lo[15:8]};
    else          r = lo;
    return r;
  endfunction

  function automatic logic [15:0] inc_sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w0    = addr_q[16:1];
  assign w1    = w0 + 16'd1;
  assign idx0  = w0[IDX_W-1:0];
  assign idx1  = w1[IDX_W-1:0];
  assign tag0  = w0[15:IDX_W];
  assign tag1  = w1[15:IDX_W];
  assign hit0  = valid_q[idx0] && (tag_q[idx0] == tag0);
  assign hit1  = valid_q[idx1] && (tag_q[idx1] == tag1);
  assign need1 = !byte_q && addr_q[0];

  assign cpu_ack  = (state_q == S_RESP);
  assign cpu_data = cpu_data_q;
  assign fl_req   = fl_req_q;
  assign fl_addr  = fl_addr_q;
  assign miss_cnt = miss_cnt_q;

  // Next-state, fill write and response formation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byte_d     = byte_q;
    d0_d       = d0_q;
    d1_d       = d1_q;
    cpu_data_d = cpu_data_q;
    fl_req_d   = fl_req_q;
    fl_addr_d  = fl_addr_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    wr_en      = 1'b0;
    wr_idx     = idx0;
    wr_tag     = tag0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          byte_d  = cpu_byte;
          state_d = S_LOOK0;
        end
      end
      S_LOOK0: begin
        if (hit0) begin
          d0_d    = data_q[idx0];
          state_d = need1 ? S_LOOK1 : S_RESP;
        end else begin
          state_d    = S_FILL0;
          fl_req_d   = 1'b1;
          fl_addr_d  = w0;
          miss_cnt_d = inc_sat(miss_cnt_q);
        end
      end
      S_FILL0: begin
        if (fl_req_q && fl_ack) begin
          wr_en    = 1'b1;
          d0_d     = fl_rdata;
          fl_req_d = 1'b0;
          state_d  = need1 ? S_LOOK1 : S_RESP;
        end
      end
      S_LOOK1: begin
        if (hit1) begin
          d1_d    = data_q[idx1];
          state_d = S_RESP;
        end else begin
          state_d    = S_FILL1;
          fl_req_d   = 1'b1;
          fl_addr_d  = w1;
          miss_cnt_d = inc_sat(miss_cnt_q);
        end
      end
      S_FILL1: begin
        wr_idx = idx1;
        wr_tag = tag1;
        if (fl_req_q && fl_ack) begin
          wr_en    = 1'b1;
          d1_d     = fl_rdata;
          fl_req_d = 1'b0;
          state_d  = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wr_en) valid_d[wr_idx] = 1'b1;
    // A flush wins over a same-cycle fill: the entry stays invalid.
    if (flush) valid_d = '0;

    if (state_d == S_RESP && state_q != S_RESP)
      cpu_data_d = form_data(byte_q, addr_q[0], d0_d, d1_d);
  end

  // Control and response registers, cleared by reset.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cpu_data_q <= '0;
      fl_req_q   <= 1'b0;
      fl_addr_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cpu_data_q <= cpu_data_d;
      fl_req_q   <= fl_req_d;
      fl_addr_q  <= fl_addr_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
    end
  end

  // Request latch, fetched words and tag/data store (no reset needed).
  always_ff @(posedge sys_clk) begin
    addr_q <= addr_d;
    byte_q <= byte_d;
    d0_q   <= d0_d;
    d1_q   <= d1_d;
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= fl_rdata;
    end
  end

endmodule

// File: tb/tb_flash_rd_cache.sv
// Bench for flash_rd_cache: directed test-plan steps plus randomized reads,
// checked against a word-level cache/flash model.
module tb_flash_rd_cache;

  logic        sys_clk, reset_n, cpu_req, cpu_byte, cpu_ack;
  logic        flush, flush_m, flush_r, fl_req, fl_ack;
  logic [16:0] cpu_addr;
  logic [15:0] cpu_data, fl_addr, fl_rdata, miss_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] fetchq [$];
  int resp_dly = 1;
  int fwa_req = 0;
  int fwa_done = 0;

  bit          in_cache [int];
  bit          fwa_pending = 0;
  int          exp_miss = 0;
  logic [15:0] last_data;

  assign flush = flush_m | flush_r;

  flash_rd_cache #(.ENTRIES(16)) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .cpu_req (cpu_req),
    .cpu_addr(cpu_addr),
    .cpu_byte(cpu_byte),
    .cpu_data(cpu_data),
    .cpu_ack (cpu_ack),
    .flush   (flush),
    .fl_req  (fl_req),
    .fl_addr (fl_addr),
    .fl_rdata(fl_rdata),
    .fl_ack  (fl_ack),
    .miss_cnt(miss_cnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Flash controller: acks resp_dly cycles after fl_req rises, data from mem.
  initial begin : responder
    int wcnt;
    wcnt = 0;
    fl_ack = 1'b0;
    fl_rdata = '0;
    flush_r = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      flush_r = 1'b0;
      if (fl_ack) fl_ack = 1'b0;
      else if (fl_req) begin
        if (wcnt < resp_dly) wcnt++;
        else begin
          fl_ack = 1'b1;
          fl_rdata = mem[fl_addr];
          fetchq.push_back(fl_addr);
          wcnt = 0;
          if (fwa_req != fwa_done) begin
            flush_r = 1'b1;
            fwa_done++;
          end
        end
      end else wcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Direct-mapped model: a word evicts whichever cached word shares its low 4 bits.
  task automatic model_insert(input int w);
    int victim;
    victim = -1;
    foreach (in_cache[k]) if ((k % 16) == (w % 16)) victim = k;
    if (victim >= 0) in_cache.delete(victim);
    in_cache[w] = 1'b1;
  endtask

  function automatic logic [15:0] ref_data(input logic [16:0] a, input bit b);
    int w0, w1, v;
    w0 = int'(a) / 2;
    w1 = (w0 + 1) % 65536;
    if (b) begin
      v = (a % 2 == 1) ? int'(mem[w0]) / 256 : int'(mem[w0]) % 256;
      if (v >= 128) v -= 256;
      return 16'(v);
    end
    if (a % 2 == 1) return 16'((int'(mem[w1]) % 256) * 256 + int'(mem[w0]) / 256);
    return mem[w0];
  endfunction

  task automatic do_read(input logic [16:0] a, input bit b, input string tag);
    int words [$];
    int exp_f [$];
    int w0, lat_exp, lat, base;
    bit need1;
    logic [15:0] dexp;
    w0 = int'(a) / 2;
    need1 = !b && (a % 2 == 1);
    words.push_back(w0);
    if (need1) words.push_back((w0 + 1) % 65536);
    lat_exp = need1 ? 3 : 2;
    foreach (words[i]) begin
      if (!in_cache.exists(words[i])) begin
        exp_f.push_back(words[i]);
        lat_exp += resp_dly + 1;
        if (fwa_pending) begin
          in_cache.delete();
          fwa_pending = 0;
        end else model_insert(words[i]);
      end
    end
    exp_miss += exp_f.size();
    dexp = ref_data(a, b);
    base = fetchq.size();

    cpu_addr = a;
    cpu_byte = b;
    cpu_req = 1'b1;
    lat = 0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge sys_clk); #1;
      if (cpu_ack) begin
        lat = c;
        break;
      end
    end
    cpu_req = 1'b0;
    chk({tag, " latency"}, lat, lat_exp);
    chk({tag, " data"}, cpu_data, dexp);
    last_data = cpu_data;
    @(posedge sys_clk); #1;
    chk({tag, " ack pulse"}, cpu_ack, 0);
    chk({tag, " data held"}, cpu_data, dexp);
    chk({tag, " fetch count"}, fetchq.size() - base, exp_f.size());
    foreach (exp_f[i])
      if (base + i < fetchq.size()) chk({tag, " fetch addr"}, fetchq[base + i], exp_f[i]);
    chk({tag, " miss_cnt"}, miss_cnt, exp_miss);
  endtask

  task automatic do_flush();
    flush_m = 1'b1;
    @(posedge sys_clk); #1;
    flush_m = 1'b0;
    in_cache.delete();
  endtask

  initial begin : main
    int found, seen_ack;
    logic [16:0] ra;
    reset_n = 1'b0;
    cpu_req = 1'b0;
    cpu_addr = '0;
    cpu_byte = 1'b0;
    flush_m = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset cpu_ack", cpu_ack, 0);
    chk("reset cpu_data", cpu_data, 0);
    chk("reset fl_req", fl_req, 0);
    chk("reset fl_addr", fl_addr, 0);
    chk("reset miss_cnt", miss_cnt, 0);
    #2 reset_n = 1'b1;
    @(posedge sys_clk); #1;

    // Aligned miss then hit
    mem[16'h0008] = 16'hBEEF;
    resp_dly = 3;
    do_read(17'h00010, 1'b0, "miss1");
    chk("tp beef", last_data, 16'hBEEF);
    chk("tp miss_cnt 1", miss_cnt, 1);
    do_read(17'h00010, 1'b0, "hit1");
    chk("tp miss_cnt still 1", miss_cnt, 1);

    // Flush forces a refetch
    do_flush();
    do_read(17'h00010, 1'b0, "after flush");

    // Byte reads, sign extension
    do_flush();
    mem[16'h0008] = 16'h80F1;
    resp_dly = 1;
    do_read(17'h00010, 1'b1, "byte lo");
    chk("tp byte lo", last_data, 16'hFFF1);
    do_read(17'h00011, 1'b1, "byte hi");
    chk("tp byte hi", last_data, 16'hFF80);
    do_flush();
    mem[16'h0008] = 16'h7F01;
    do_read(17'h00011, 1'b1, "byte pos");
    chk("tp byte pos", last_data, 16'h007F);

    // Unaligned word, two misses
    do_flush();
    mem[16'h0008] = 16'h1234;
    mem[16'h0009] = 16'hAB56;
    resp_dly = 2;
    do_read(17'h00011, 1'b0, "unaligned");
    chk("tp unaligned", last_data, 16'h5612);

    // Wrap from word 0xFFFF to 0x0000
    do_flush();
    do_read(17'h1FFFF, 1'b0, "wrap");

    // Flush coincident with fl_ack
    fwa_req++;
    fwa_pending = 1;
    resp_dly = 1;
    do_read(17'h00040, 1'b0, "flush at ack");
    do_read(17'h00040, 1'b0, "reread after flush at ack");

    // Randomized reads
    for (int n = 0; n < 40; n++) begin
      ra = 17'($urandom_range(0, 95));
      if ($urandom_range(0, 3) == 0) ra = ra | 17'h1FF80;
      resp_dly = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) do_flush();
      if (!fwa_pending && $urandom_range(0, 9) == 0) begin
        fwa_req++;
        fwa_pending = 1;
      end
      do_read(ra, 1'($urandom_range(0, 1)), "rand");
    end
    // Drain any armed flush-with-ack so it cannot land on the aborted fetch
    if (fwa_pending) do_read(17'h01000 + 17'($urandom_range(0, 31) * 32), 1'b0, "drain");

    // Reset while a fetch is outstanding
    do_read(17'h00010, 1'b0, "prime");
    do_flush();
    resp_dly = 1000;
    cpu_addr = 17'h00400;
    cpu_byte = 1'b0;
    cpu_req = 1'b1;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge sys_clk); #1;
      if (fl_req) begin
        found = 1;
        break;
      end
    end
    chk("rst fl_req seen", found, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst fl_req drop", fl_req, 0);
    chk("rst cpu_ack", cpu_ack, 0);
    chk("rst miss_cnt", miss_cnt, 0);
    cpu_req = 1'b0;
    seen_ack = 0;
    repeat (3) begin
      @(posedge sys_clk); #1;
      if (cpu_ack) seen_ack = 1;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge sys_clk); #1;
      if (cpu_ack) seen_ack = 1;
    end
    chk("rst no ack", seen_ack, 0);
    in_cache.delete();
    exp_miss = 0;
    resp_dly = 1;
    do_read(17'h00010, 1'b0, "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flash_rd_cache.md
# flash_rd_cache

Direct-mapped read cache between the CPU memory path and the flash PROM word-fetch controller. It accepts byte or word reads at any byte address and serves hits from a 16-entry word store. Misses go to the flash controller as aligned 16-bit word fetches. Unaligned word reads are assembled from two words, and byte reads are returned sign-extended.

## Interface
- `ENTRIES`, 16: number of cached words; fixed at 16, so the index is `cpu_addr[4:1]` and the tag is `cpu_addr[16:5]` (12 bits).
- `sys_clk` in 1: the only clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: read request; held high until `cpu_ack`.
- `cpu_addr` in 17: byte address; sampled with the request.
- `cpu_byte` in 1: 1 = byte read, 0 = word read; sampled with the request.
- `cpu_data` out 16: read data; valid while `cpu_ack`=1 and held until the next ack.
- `cpu_ack` out 1: one-cycle completion pulse.
- `flush` in 1: one-cycle pulse that invalidates all entries.
- `fl_req` out 1: word fetch request to the flash controller.
- `fl_addr` out 16: word address of the fetch.
- `fl_rdata` in 16: fetched word; valid in the `fl_ack` cycle.
- `fl_ack` in 1: one-cycle fetch completion.
- `miss_cnt` out 16: saturating count of flash fetches issued.

## Operation
- Storage per entry: valid bit, 12-bit tag, 16-bit data. Reset clears every valid bit.
- Word addresses:
  - `w0` = `cpu_addr[16:1]`.
  - `w1` = `w0 + 1`, modulo 2^16, so 0xFFFF wraps to 0x0000.
  - `w1` is needed only when `cpu_byte`=0 and `cpu_addr[0]`=1.
- FSM states: IDLE, LOOK0, FILL0, LOOK1, FILL1, RESP.
- IDLE: when `cpu_req`=1, latch `cpu_addr` and `cpu_byte`, then go to LOOK0.
- LOOK0:
  - On a `w0` hit, capture the word into `d0`.
  - Then go to LOOK1 if `w1` is needed, otherwise to RESP.
  - On a miss, go to FILL0.
- FILL0: hold `fl_req`=1 and `fl_addr`=`w0`.
  - On `fl_ack`: write the entry, capture `d0`, and drop `fl_req` in the same cycle.
  - Then go to LOOK1 or RESP, using the same rule as LOOK0.
- LOOK1 / FILL1: same as LOOK0 / FILL0 for `w1`, capturing `d1` and going to RESP.
- RESP: `cpu_ack`=1 for one cycle, then return to IDLE.
- `cpu_data` formation, where `a0` is the latched `cpu_addr[0]`:
  - byte, `a0`=0: `{8{d0[7]}, d0[7:0]}`.
  - byte, `a0`=1: `{8{d0[15]}, d0[15:8]}`.
  - word, `a0`=0: `d0`.
  - word, `a0`=1: `{d1[7:0], d0[15:8]}`.
- Flush behaviour:
  - `flush` clears all valid bits in the cycle it is seen.
  - If a fill write lands in the same cycle as `flush`, the entry stays invalid, but the fetched data is still captured and returned.
  - A flush does not abort an in-flight request.
- When `w0` and `w1` map to the same index (they cannot, since the indices differ by 1 mod 16), no aliasing case exists. No special handling is required.
- `miss_cnt` increments by 1 on entry to FILL0 or FILL1 and saturates at 0xFFFF. Reset clears it; `flush` does not.

## Timing
- Reset values: `cpu_ack`=0, `cpu_data`=0, `fl_req`=0, `fl_addr`=0, `miss_cnt`=0, state=IDLE.
- Reset asserted mid-operation forces IDLE immediately and drops `fl_req`. No `cpu_ack` is issued for the aborted request.
- Latency is counted from the edge that samples `cpu_req` (cycle 0):
  - Aligned hit, or any byte hit: `cpu_ack` in cycle 2.
  - Unaligned word with two hits: `cpu_ack` in cycle 3.
  - Each miss adds (cycles from `fl_req` rising to `fl_ack`) + 1.
- `fl_req` rises in the cycle after LOOK detects the miss.
- `fl_addr` is stable while `fl_req`=1.
- `fl_ack` is ignored when `fl_req`=0.
- A new `cpu_req` is accepted no earlier than the cycle after `cpu_ack`. A request held high across the ack is treated as a new request.
- Lookup uses the tag/valid state as of the start of the LOOK cycle. A fill written in FILL0 is visible to LOOK1.

## Test plan
- Reset, then word read of 0x00010 with `fl_ack` 3 cycles after `fl_req` and `fl_rdata`=0xBEEF:
  - one fetch at `fl_addr`=0x0008; `cpu_data`=0xBEEF; `miss_cnt`=1.
  - Repeating the read gives `cpu_ack` in cycle 2, no `fl_req`, and `miss_cnt` still 1.
- Byte reads after caching word 0x0008=0x80F1:
  - addr 0x00010 returns 0xFFF1; addr 0x00011 returns 0xFF80.
  - After caching 0x0008=0x7F01, addr 0x00011 returns 0x007F.
- Unaligned word read at 0x00011 with word 0x0008=0x1234 and word 0x0009=0xAB56, both misses:
  - two fetches, to 0x0008 then 0x0009; `cpu_data`=0x5612; `miss_cnt`=2.
- Wrap: word read at 0x1FFFF:
  - fetches 0xFFFF, then 0x0000; result is `{d1[7:0], d0[15:8]}`.
- Flush:
  - After the first scenario, pulse `flush`; re-reading 0x00010 issues a fetch.
  - `flush` coincident with `fl_ack` returns correct data, but the next read of the same address misses again.
- Deassert `reset_n` while `fl_req`=1: `fl_req` drops immediately, no `cpu_ack`, all entries invalid after release.
